// File: rtl/voice_dispatcher.sv
// vd_fifo: generic circular request buffer with synchronous flush.
// Latency: a write is visible at rd_dat one cycle later; reads are combinational from the head.
// Backpressure: writes are ignored while full, reads while empty; flush beats both.
module vd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_wr  = wr_vld & !full;
  assign do_rd  = rd_rdy & !empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; occupancy is governed by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_dat;
  end
endmodule

// voice_dispatcher: buffers note requests and loads them round-robin onto free note_player voices.
// Latency: request accepted at edge E into an empty FIFO loads a free voice at edge E+1.
// Backpressure: note_ready = !full; a request presented while full is dropped and flags overflow_err.
module voice_dispatcher #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  flush,
  input  logic                  note_valid,
  input  logic [NOTE_W-1:0]     note,
  input  logic [DUR_W-1:0]      duration,
  output logic                  note_ready,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] load_voice,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [DUR_W-1:0]      voice_duration,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  overflow_err
);
  localparam int RR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } req_t;

  req_t                  wr_req;
  req_t                  head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  load_go;
  logic                  zero_dur;
  logic                  found;
  logic [RR_W-1:0]       rr_ptr;
  logic [RR_W-1:0]       target;
  logic [RR_W-1:0]       idx;
  logic [NUM_VOICES-1:0] target_onehot;

  assign wr_req     = {note, duration};
  assign note_ready = !full;
  assign push       = note_valid & !full;

  vd_fifo #(.W($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .flush  (flush),
    .wr_vld (push),
    .wr_dat (wr_req),
    .rd_rdy (pop),
    .rd_dat (head),
    .full   (full),
    .empty  (empty)
  );

  // First free voice at or above rr_ptr, wrapping past the top voice.
  always_comb begin
    found  = 1'b0;
    target = rr_ptr;
    idx    = rr_ptr;
    for (int k = 0; k < NUM_VOICES; k++) begin
      if (!found && !voice_busy[idx]) begin
        found  = 1'b1;
        target = idx;
      end
      idx = (idx == RR_W'(NUM_VOICES-1)) ? '0 : idx + 1'b1;
    end
  end

  assign target_onehot = NUM_VOICES'(1) << target;
  assign zero_dur      = (head.dur == '0);
  // Zero-duration heads are discarded without needing a free voice.
  assign pop           = play & !empty & !flush & (zero_dur | found);
  assign load_go       = pop & !zero_dur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_voice     <= '0;
      voice_note     <= '0;
      voice_duration <= '0;
      voice_busy     <= '0;
      overflow_err   <= 1'b0;
      rr_ptr         <= '0;
    end else begin
      load_voice <= '0;
      voice_busy <= (voice_busy & ~voice_done) | (load_go ? target_onehot : '0);
      if (flush)                  overflow_err <= 1'b0;
      else if (note_valid && full) overflow_err <= 1'b1;
      if (load_go) begin
        load_voice     <= target_onehot;
        voice_note     <= head.note;
        voice_duration <= head.dur;
        rr_ptr         <= (target == RR_W'(NUM_VOICES-1)) ? '0 : target + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_voice_dispatcher.sv
// Directed vector table plus a hand-written asynchronous-reset sequence for voice_dispatcher.
module tb_voice_dispatcher;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play = 1'b0;
  logic       flush = 1'b0;
  logic       note_valid = 1'b0;
  logic [5:0] note = '0;
  logic [5:0] duration = '0;
  logic [2:0] voice_done = '0;
  logic       note_ready;
  logic [2:0] load_voice;
  logic [5:0] voice_note;
  logic [5:0] voice_duration;
  logic [2:0] voice_busy;
  logic       overflow_err;

  voice_dispatcher #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .play           (play),
    .flush          (flush),
    .note_valid     (note_valid),
    .note           (note),
    .duration       (duration),
    .note_ready     (note_ready),
    .voice_done     (voice_done),
    .load_voice     (load_voice),
    .voice_note     (voice_note),
    .voice_duration (voice_duration),
    .voice_busy     (voice_busy),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       play;
    logic       flush;
    logic       nv;
    logic [5:0] note;
    logic [5:0] dur;
    logic [2:0] done;
    logic       rdy;
    logic [2:0] load;
    logic [5:0] vn;
    logic [5:0] vd;
    logic [2:0] busy;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic pl, input logic fl, input logic nv,
                     input logic [5:0] nt, input logic [5:0] du, input logic [2:0] dn,
                     input logic rdy, input logic [2:0] ld, input logic [5:0] vn,
                     input logic [5:0] vd, input logic [2:0] bz, input logic ovf);
    vec_t v;
    v.rst = rst; v.play = pl; v.flush = fl; v.nv = nv; v.note = nt; v.dur = du; v.done = dn;
    v.rdy = rdy; v.load = ld; v.vn = vn; v.vd = vd; v.busy = bz; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name, input logic rdy, input logic [2:0] ld,
                           input logic [5:0] vn, input logic [5:0] vd,
                           input logic [2:0] bz, input logic ovf);
    n_tests++;
    if ({note_ready, load_voice, voice_note, voice_duration, voice_busy, overflow_err} !==
        {rdy, ld, vn, vd, bz, ovf}) begin
      n_fail++;
      $display("FAIL %s: rdy/load/note/dur/busy/ovf got %b/%b/%0d/%0d/%b/%b want %b/%b/%0d/%0d/%b/%b",
               name, note_ready, load_voice, voice_note, voice_duration, voice_busy, overflow_err,
               rdy, ld, vn, vd, bz, ovf);
    end
  endtask

  initial begin
    // args: rst play flush nv note dur done | rdy load vn vd busy ovf
    // single request -> voice 0
    add(0,1,0,1,12,8,0, 1,3'b000,0,0,3'b000,0);
    add(0,1,0,0, 0,0,0, 1,3'b001,12,8,3'b001,0);
    add(0,1,0,0, 0,0,0, 1,3'b000,12,8,3'b001,0);
    // back-to-back round robin, done on voice 1, rr_ptr ends at 2
    add(1,0,0,0, 0,0,0, 1,3'b000,0,0,3'b000,0);
    add(0,1,0,1, 5,4,0, 1,3'b000,0,0,3'b000,0);
    add(0,1,0,1, 7,4,0, 1,3'b001,5,4,3'b001,0);
    add(0,1,0,1, 9,4,0, 1,3'b010,7,4,3'b011,0);
    add(0,1,0,1,11,4,0, 1,3'b100,9,4,3'b111,0);
    add(0,1,0,0, 0,0,0, 1,3'b000,9,4,3'b111,0);
    add(0,1,0,0, 0,0,3'b010, 1,3'b000,9,4,3'b101,0);
    add(0,1,0,0, 0,0,0, 1,3'b010,11,4,3'b111,0);
    add(0,1,0,0, 0,0,0, 1,3'b000,11,4,3'b111,0);
    add(0,1,0,0, 0,0,3'b101, 1,3'b000,11,4,3'b010,0);
    add(0,1,0,1,13,5,0, 1,3'b000,11,4,3'b010,0);
    add(0,1,0,0, 0,0,0, 1,3'b100,13,5,3'b110,0);
    // play low fills FIFO, overflow, then play releases three loads
    add(1,0,0,0, 0,0,0, 1,3'b000,0,0,3'b000,0);
    add(0,0,0,1, 1,2,0, 1,3'b000,0,0,3'b000,0);
    add(0,0,0,1, 2,2,0, 1,3'b000,0,0,3'b000,0);
    add(0,0,0,1, 3,2,0, 1,3'b000,0,0,3'b000,0);
    add(0,0,0,1, 4,2,0, 0,3'b000,0,0,3'b000,0);
    add(0,0,0,1, 5,2,0, 0,3'b000,0,0,3'b000,1);
    add(0,1,0,1, 6,2,0, 1,3'b001,1,2,3'b001,1);
    add(0,1,0,0, 0,0,0, 1,3'b010,2,2,3'b011,1);
    add(0,1,0,0, 0,0,0, 1,3'b100,3,2,3'b111,1);
    add(0,1,0,0, 0,0,0, 1,3'b000,3,2,3'b111,1);
    add(0,1,0,0, 0,0,3'b001, 1,3'b000,3,2,3'b110,1);
    add(0,1,0,0, 0,0,0, 1,3'b001,4,2,3'b111,1);
    add(0,1,0,0, 0,0,3'b111, 1,3'b000,4,2,3'b000,1);
    add(0,1,0,0, 0,0,0, 1,3'b000,4,2,3'b000,1);
    // zero-duration head dropped, next entry loads voice 0
    add(1,0,0,0, 0,0,0, 1,3'b000,0,0,3'b000,0);
    add(0,1,0,1, 7,0,0, 1,3'b000,0,0,3'b000,0);
    add(0,1,0,1,20,3,0, 1,3'b000,0,0,3'b000,0);
    add(0,1,0,0, 0,0,0, 1,3'b001,20,3,3'b001,0);
    // flush with all voices busy and overflow set; flush beats push and pop
    add(1,0,0,0, 0,0,0, 1,3'b000,0,0,3'b000,0);
    add(0,1,0,1, 1,1,0, 1,3'b000,0,0,3'b000,0);
    add(0,1,0,1, 2,1,0, 1,3'b001,1,1,3'b001,0);
    add(0,1,0,1, 3,1,0, 1,3'b010,2,1,3'b011,0);
    add(0,1,0,1, 4,1,0, 1,3'b100,3,1,3'b111,0);
    add(0,1,0,1, 5,1,0, 1,3'b000,3,1,3'b111,0);
    add(0,1,0,1, 6,1,0, 1,3'b000,3,1,3'b111,0);
    add(0,1,0,1, 7,1,0, 0,3'b000,3,1,3'b111,0);
    add(0,1,0,1, 8,1,0, 0,3'b000,3,1,3'b111,1);
    add(0,1,1,1, 9,1,0, 1,3'b000,3,1,3'b111,0);
    add(0,1,0,0, 0,0,3'b100, 1,3'b000,3,1,3'b011,0);
    add(0,1,0,0, 0,0,0, 1,3'b000,3,1,3'b011,0);
    add(0,1,0,1,10,1,0, 1,3'b000,3,1,3'b011,0);
    add(0,1,1,0, 0,0,0, 1,3'b000,3,1,3'b011,0);
    add(0,1,0,0, 0,0,0, 1,3'b000,3,1,3'b011,0);

    #1;
    check_out("reset_state", 1'b1, 3'b000, 6'd0, 6'd0, 3'b000, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset      = !vecs[i].rst;
      play       = vecs[i].play;
      flush      = vecs[i].flush;
      note_valid = vecs[i].nv;
      note       = vecs[i].note;
      duration   = vecs[i].dur;
      voice_done = vecs[i].done;
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].load, vecs[i].vn, vecs[i].vd,
                vecs[i].busy, vecs[i].ovf);
    end

    // asynchronous reset while a load pulse is high
    @(negedge clk);
    reset = 1'b0; play = 1'b1; flush = 1'b0; note_valid = 1'b0; voice_done = '0;
    @(negedge clk);
    reset = 1'b1; note_valid = 1'b1; note = 6'd12; duration = 6'd8;
    @(negedge clk);
    note_valid = 1'b0;
    @(posedge clk);
    #1;
    check_out("t6_load_high", 1'b1, 3'b001, 6'd12, 6'd8, 3'b001, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_out("t6_async_clear", 1'b1, 3'b000, 6'd0, 6'd0, 3'b000, 1'b0);
    note_valid = 1'b1; note = 6'd30; duration = 6'd5;
    @(posedge clk);
    #1;
    check_out("t6_held_in_reset", 1'b1, 3'b000, 6'd0, 6'd0, 3'b000, 1'b0);
    @(negedge clk);
    reset = 1'b1; note = 6'd33; duration = 6'd9;
    @(negedge clk);
    note_valid = 1'b0;
    @(posedge clk);
    #1;
    check_out("t6_first_after_release", 1'b1, 3'b001, 6'd33, 6'd9, 3'b001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
